// File: rtl/prefetch_queue.sv
// rtl/prefetch_queue.sv - instruction prefetch queue with fetch PC and first-word fall-through head
//
// Purpose: fetches sequential instruction words from a same-cycle instruction
// memory, buffers {pc, ir} pairs in a DEPTH-entry circular queue and presents
// the oldest entry to decode. A redirect flushes the queue and reloads the
// fetch PC.
//
// Ports:
//   clk1        - clock, all state updates on the rising edge
//   reset       - asynchronous active-low reset
//   imem_addr   - fetch address (current fetch PC)
//   imem_data   - instruction word at imem_addr, same cycle
//   imem_valid  - imem_data is valid this cycle
//   redirect    - flush and refetch from redirect_pc
//   redirect_pc - new fetch address (low two bits dropped)
//   deq_ready   - decode accepts the head entry
//   deq_valid   - head entry present
//   deq_pc      - PC of head entry (holds last head when empty)
//   deq_npc     - deq_pc + 4
//   deq_ir      - instruction of head entry (NOP when empty)
//   count       - occupied entries
//   full/empty  - count == DEPTH / count == 0
module prefetch_queue #(
  parameter int unsigned     XLEN     = 32,
  parameter int unsigned     DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic                       clk1,
  input  logic                       reset,
  output logic [XLEN-1:0]            imem_addr,
  input  logic [31:0]                imem_data,
  input  logic                       imem_valid,
  input  logic                       redirect,
  input  logic [XLEN-1:0]            redirect_pc,
  input  logic                       deq_ready,
  output logic                       deq_valid,
  output logic [XLEN-1:0]            deq_pc,
  output logic [XLEN-1:0]            deq_npc,
  output logic [31:0]                deq_ir,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);

  localparam int unsigned PW  = $clog2(DEPTH);
  localparam int unsigned CW  = $clog2(DEPTH+1);
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic [XLEN-1:0] pc_mem [DEPTH];
  logic [31:0]     ir_mem [DEPTH];

  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  // Last head PC seen, so deq_pc/deq_npc hold their value while empty.
  logic [XLEN-1:0] hold_pc_q, hold_pc_d;

  logic enq, deq;

  assign empty     = (count_q == '0);
  assign full      = (count_q == CW'(DEPTH));
  assign count     = count_q;
  assign deq_valid = !empty;
  assign imem_addr = fetch_pc_q;

  // Dequeue makes room in the same cycle, so a full queue can still accept.
  assign deq = deq_valid && deq_ready && !redirect;
  assign enq = imem_valid && !redirect && (!full || deq);

  assign deq_pc  = empty ? hold_pc_q : pc_mem[rd_ptr_q];
  assign deq_npc = deq_pc + XLEN'(4);
  assign deq_ir  = empty ? NOP : ir_mem[rd_ptr_q];

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    hold_pc_d  = deq_pc;
    if (redirect) begin
      // Masking the whole word keeps the low address bits out of the PC.
      fetch_pc_d = redirect_pc & ~XLEN'(3);
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
    end else begin
      if (enq) begin
        fetch_pc_d = fetch_pc_q + XLEN'(4);
        wr_ptr_d   = wr_ptr_q + 1'b1;
      end
      if (deq) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      case ({enq, deq})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk1 or negedge reset) begin
    if (!reset) begin
      fetch_pc_q <= RESET_PC;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      hold_pc_q  <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      hold_pc_q  <= hold_pc_d;
    end
  end

  // Storage needs no reset: entries are only read while count is nonzero.
  always_ff @(posedge clk1) begin
    if (enq) begin
      pc_mem[wr_ptr_q] <= fetch_pc_q;
      ir_mem[wr_ptr_q] <= imem_data;
    end
  end

endmodule

// File: doc/prefetch_queue.md
PREFETCH_QUEUE -- requirements
Module: prefetch_queue

Interface
REQ-001 SHALL have parameter XLEN, default 32: PC and address width.
REQ-002 SHALL have parameter DEPTH, default 4: queue entries; power of two, >=2.
REQ-003 SHALL have parameter RESET_PC, default 0: fetch address after reset.
REQ-004 SHALL have port clk1  input  1: single clock; all state updates on rising edge.
REQ-005 SHALL have port reset  input  1: asynchronous, active-low reset.
REQ-006 SHALL have port imem_addr  output  XLEN: fetch address to instruction memory, combinational from the fetch PC.
REQ-007 SHALL have port imem_data  input  32: instruction word at imem_addr, same cycle.
REQ-008 SHALL have port imem_valid  input  1: imem_data is valid this cycle.
REQ-009 SHALL have port redirect  input  1: taken branch/jump; flush and refetch.
REQ-010 SHALL have port redirect_pc  input  XLEN: new fetch address when redirect=1.
REQ-011 SHALL have port deq_ready  input  1: decode accepts the head entry.
REQ-012 SHALL have port deq_valid  output  1: head entry is present.
REQ-013 SHALL have port deq_pc  output  XLEN: PC of head entry.
REQ-014 SHALL have port deq_npc  output  XLEN: deq_pc+4 (mod 2^XLEN).
REQ-015 SHALL have port deq_ir  output  32: instruction of head entry.
REQ-016 SHALL have port count  output  $clog2(DEPTH+1): occupied entries.
REQ-017 SHALL have ports full, empty  output  1 each: count==DEPTH, count==0.

Function
REQ-018 SHALL hold a fetch PC register and a circular buffer of DEPTH {pc, ir} entries with read/write pointers wrapping modulo DEPTH.
REQ-019 SHALL drive imem_addr = fetch PC.
REQ-020 SHALL enqueue when imem_valid=1, redirect=0 and (full=0 or a dequeue occurs the same cycle); entry = {fetch PC, imem_data}; fetch PC advances by 4 (mod 2^XLEN, wraps to 0).
REQ-021 SHALL dequeue when deq_valid=1, deq_ready=1 and redirect=0; read pointer advances by one.
REQ-022 SHALL keep deq_valid = !empty; head fields SHALL be first-word fall-through (visible in the cycle after enqueue, no further latency).
REQ-023 SHALL hold deq_pc/deq_ir stable while deq_valid=1 and deq_ready=0.
REQ-024 SHALL on simultaneous enqueue and dequeue leave count unchanged, including when full.
REQ-025 SHALL when full and no dequeue, neither enqueue nor advance the fetch PC (imem_data ignored).
REQ-026 SHALL when imem_valid=0, neither enqueue nor advance the fetch PC.
REQ-027 SHALL on redirect=1 at a clock edge: empty the queue (count=0, pointers equal), load fetch PC with {redirect_pc[XLEN-1:2],2'b00}, perform no enqueue, and ignore deq_ready that cycle.
REQ-028 SHALL after redirect present the first new entry no earlier than the second edge after the redirect edge (one cycle fetch, next cycle visible).
REQ-029 SHALL keep deq_ir at 32'h00000013 (NOP) whenever empty=1; deq_pc/deq_npc then hold their last value.

Reset
REQ-030 SHALL on reset=0, asynchronously: fetch PC=RESET_PC, pointers=0, count=0, empty=1, full=0, deq_valid=0, deq_ir=NOP, deq_pc=0, deq_npc=4.
REQ-031 SHALL, with reset asserted mid-operation, discard all queued entries, and resume fetching at RESET_PC on the first edge after reset=1.

Verification
REQ-032 SHALL cover: reset release, imem_valid=1, deq_ready=0, DEPTH=4 -> entries PC 0,4,8,12 queued in 4 cycles, full=1, imem_addr holds 16.
REQ-033 SHALL cover: from full, deq_ready=1 one cycle -> entry PC 0 consumed, PC 16 enqueued same edge, count stays 4, deq_pc=4.
REQ-034 SHALL cover: count=3, redirect=1 redirect_pc=0x103 with deq_ready=1 -> count=0, imem_addr=0x100, next edge deq_pc=0x100, deq_npc=0x104.
REQ-035 SHALL cover: imem_valid toggling 1,0,1 with deq_ready=1 -> entries PC 0 then 4 only, no duplicated or skipped PC.
REQ-036 SHALL cover: fetch PC=0xFFFFFFFC, enqueue -> next imem_addr=0x00000000, deq_npc of that entry=0x00000000.
REQ-037 SHALL cover: reset=0 asserted between edges with count=2 -> outputs reach REQ-030 values without a clock edge.
